adc_recepcion: RTL and testbench

// - SPI-style receive front end for a 12-bit serial ADC (AD7476/PmodAD1 class).
// - Each frame is 16 bits, MSB first: 4 leading zeros, then 12 data bits.
// - Sits between the ADC chip-select/clock generator and the sample consumer.
// - datos is the ADC word source: bit datos[15-n] is the serial line value
//   for bit slot n (n = 0..15).
// - Output: a one-cycle done strobe plus the 12-bit sample.

---
 rtl/adc_recepcion.sv | 118 +++++++++++
 tb/tb_adc_recepcion.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/adc_recepcion.sv
// adc_recepcion: SPI-style receive front end for a 12-bit serial ADC.
// Shifts a 16-bit CS frame MSB first and strobes the 12-bit sample.
// Ports:
//   SCLK         serial clock, all logic on its rising edge
//   reset        asynchronous active-high reset
//   CS           chip select, active low
//   datos        word source, datos[15-n] is the line value in slot n
//   rx_done_tick one-cycle strobe at frame completion
//   b_reg        shift register (last or partial frame)
//   data_Out     last complete sample
// Option: define ADC_RECEPCION_ZERO_CHECK_EN to drop frames
// whose leading bits are not zero.
module adc_recepcion #(
   parameter int FRAME_BITS = 16,
   parameter int DATA_BITS  = 12
) (
   input  logic                  SCLK,
   input  logic                  reset,
   input  logic                  CS,
   input  logic [FRAME_BITS-1:0] datos,
   output logic                  rx_done_tick,
   output logic [FRAME_BITS-1:0] b_reg,
   output logic [DATA_BITS-1:0]  data_Out
);

   localparam int CW = $clog2(FRAME_BITS) + 1;
   localparam int IW = $clog2(FRAME_BITS);
   localparam int LW = FRAME_BITS - DATA_BITS;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE,
      WAIT
   } state_t;

   state_t                state, state_n;
   logic [CW-1:0]         count, count_n;
   logic [FRAME_BITS-1:0] b_n;
   logic [DATA_BITS-1:0]  data_n;
   logic                  tick_n;

   logic [IW-1:0]         slot;
   logic                  sbit;
   logic [FRAME_BITS-1:0] word;
   logic                  last;
   logic                  good;

   always_ff @(posedge SCLK or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         b_reg        <= '0;
         data_Out     <= '0;
         rx_done_tick <= 1'b0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         b_reg        <= b_n;
         data_Out     <= data_n;
         rx_done_tick <= tick_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      b_n     = b_reg;
      data_n  = data_Out;
      tick_n  = 1'b0;

      // slot n reads the word MSB first
      slot = count[IW-1:0];
      sbit = datos[IW'(FRAME_BITS-1) - slot];
      word = {b_reg[FRAME_BITS-2:0], sbit};
      last = (count == CW'(FRAME_BITS-1));

`ifdef ADC_RECEPCION_ZERO_CHECK_EN
      good = (word[FRAME_BITS-1 -: LW] == '0);
`else
      good = 1'b1;
`endif

      unique case (state)
         IDLE: begin
            // this edge only arms the frame, no bit is taken
            if (!CS) begin
               state_n = RECV;
               count_n = '0;
            end
         end
         RECV: begin
            if (CS) begin
               // abort keeps the partial word and the old sample
               state_n = IDLE;
            end else begin
               b_n     = word;
               count_n = count + 1'b1;
               if (last) begin
                  state_n = DONE;
                  if (good) begin
                     data_n = word[DATA_BITS-1:0];
                     tick_n = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            state_n = CS ? IDLE : WAIT;
         end
         WAIT: begin
            if (CS) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_adc_recepcion.sv
// tb_adc_recepcion: directed frames with a sample scoreboard
// checked whenever the receiver strobes rx_done_tick.
module tb_adc_recepcion;

   logic        SCLK = 1'b0;
   logic        reset;
   logic        CS;
   logic [15:0] datos;
   logic        rx_done_tick;
   logic [15:0] b_reg;
   logic [11:0] data_Out;

   adc_recepcion dut (
      .SCLK         (SCLK),
      .reset        (reset),
      .CS           (CS),
      .datos        (datos),
      .rx_done_tick (rx_done_tick),
      .b_reg        (b_reg),
      .data_Out     (data_Out)
   );

   always #5 SCLK = ~SCLK;

   int          vecs  = 0;
   int          errs  = 0;
   int          ticks = 0;
   int          cyc   = 0;
   int          tick_cyc = -1;
   logic [11:0] exp_q[$];
   logic [15:0] b_m  = '0;
   logic [11:0] d_m  = '0;
   logic [11:0] e;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] expv);
      vecs++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   // one SCLK edge, outputs sampled on the falling edge
   task automatic step();
      @(posedge SCLK);
      @(negedge SCLK);
      cyc++;
      if (rx_done_tick === 1'b1) begin
         ticks++;
         tick_cyc = cyc;
         vecs++;
         if (exp_q.size() == 0) begin
            errs++;
            $error("FAIL unexpected_tick observed %h expected none",
                   data_Out);
         end else begin
            e = exp_q.pop_front();
            assert (data_Out === e) else begin
               errs++;
               $error("FAIL tick_data observed %h expected %h",
                      data_Out, e);
            end
         end
      end
   endtask

   function automatic bit accept(input logic [15:0] w);
`ifdef ADC_RECEPCION_ZERO_CHECK_EN
      return (w[15:12] == 4'h0);
`else
      return 1'b1;
`endif
   endfunction

   // CS low for nedges edges (first is the arming edge), then CS high
   task automatic frame(input string tag, input logic [15:0] w,
                        input int nedges);
      int t0;
      int c0;
      bit full;
      bit ok;
      full = (nedges >= 17);
      ok   = full && accept(w);
      t0   = ticks;
      c0   = cyc;
      if (ok) exp_q.push_back(w[11:0]);
      datos = w;
      CS    = 1'b0;
      for (int k = 0; k < nedges; k++) begin
         step();
         if (k >= 1 && k <= 16) b_m = {b_m[14:0], w[16-k]};
      end
      CS = 1'b1;
      step();
      if (ok) d_m = w[11:0];
      chk({tag, "_breg"}, b_reg, b_m);
      chk({tag, "_data"}, {4'h0, data_Out}, {4'h0, d_m});
      chk({tag, "_ticks"}, 16'(ticks - t0), ok ? 16'd1 : 16'd0);
      if (ok) chk({tag, "_lat"}, 16'(tick_cyc - c0), 16'd17);
   endtask

   initial begin
      reset = 1'b1;
      CS    = 1'b1;
      datos = '0;
      repeat (5) step();
      chk("rst_tick", {15'd0, rx_done_tick}, 16'd0);
      chk("rst_breg", b_reg, 16'h0000);
      chk("rst_data", {4'h0, data_Out}, 16'h0000);
      reset = 1'b0;
      step();

      frame("f0ABC", 16'h0ABC, 22);
      chk("f0ABC_const", b_reg, 16'h0ABC);
      frame("f0FFF", 16'h0FFF, 17);
      frame("f0001", 16'h0001, 17);
      chk("f0001_const", {4'h0, data_Out}, 16'h0001);

      // reset asserted in the middle of a frame
      datos = 16'h0ABC;
      CS    = 1'b0;
      repeat (10) step();
      #2 reset = 1'b1;
      #1;
      chk("midrst_breg", b_reg, 16'h0000);
      chk("midrst_data", {4'h0, data_Out}, 16'h0000);
      chk("midrst_tick", {15'd0, rx_done_tick}, 16'd0);
      CS = 1'b1;
      step();
      reset = 1'b0;
      b_m = '0;
      d_m = '0;
      step();

      // abort after 8 bits
      frame("abort", 16'h0555, 9);
      chk("abort_const", b_reg, 16'h0005);

      frame("fFABC", 16'hFABC, 17);
      frame("long30", 16'h0123, 30);
      frame("f0800", 16'h0800, 17);

      vecs++;
      assert (exp_q.size() == 0) else begin
         errs++;
         $error("FAIL missing_ticks observed %0d expected 0",
                exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
